// File: rtl/bmem_pkg.sv
// rtl/bmem_pkg.sv - shared constants and grant encoding for the row-buffer port arbiter
package bmem_pkg;

  localparam int BMEM_DEPTH  = 480;
  localparam int BMEM_AW     = 9;
  localparam int BMEM_DW     = 5120;
  localparam int BMEM_RD_LAT = 2;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } gnt_e;

endpackage

// File: rtl/bmem_rr_arb2.sv
// rtl/bmem_rr_arb2.sv - two-requester arbiter, req/gnt bit 0 = write, bit 1 = read
// BMEM_ARB_WR_PRIO_EN selects fixed write priority; default is round-robin on last_grant.
module bmem_rr_arb2
  import bmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  gnt_e last_grant;

  // Nothing is granted while reset is applied, so no request is half-accepted.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
`ifdef BMEM_ARB_WR_PRIO_EN
          gnt = 2'b01;
`else
          gnt = (last_grant == GNT_RD) ? 2'b01 : 2'b10;
`endif
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_RD;
    end else if (gnt[0]) begin
      last_grant <= GNT_WR;
    end else if (gnt[1]) begin
      last_grant <= GNT_RD;
    end
  end

endmodule

// File: rtl/bmem_port_arbiter.sv
// rtl/bmem_port_arbiter.sv - shares a dual-port row buffer between a row writer and a two-row reader
// Define BMEM_ARB_WR_PRIO_EN for fixed write priority instead of round-robin arbitration.
module bmem_port_arbiter
  import bmem_pkg::*;
#(
  parameter int DEPTH = BMEM_DEPTH,
  parameter int AW    = BMEM_AW,
  parameter int DW    = BMEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data1,
  output logic [DW-1:0] rsp_data2,
  output logic          rsp_oob,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr1,
  output logic [AW-1:0] mem_addr2,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout1,
  input  logic [DW-1:0] mem_dout2,
  output logic          err_oob
);

  logic [1:0]             gnt;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   wr_oob;
  logic                   rd_oob;
  logic [BMEM_RD_LAT-1:0] pipe_v;
  logic [BMEM_RD_LAT-1:0] pipe_oob;

  bmem_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({rd_valid, wr_valid}),
    .gnt (gnt)
  );

  assign wr_acc   = gnt[0];
  assign rd_acc   = gnt[1];
  assign wr_ready = wr_acc;
  assign rd_ready = rd_acc;

  // DEPTH need not be a power of two, so the top of the address space is unbacked.
  assign wr_oob = (int'(wr_addr) >= DEPTH);
  assign rd_oob = (int'(rd_addr1) >= DEPTH) || (int'(rd_addr2) >= DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr1 <= '0;
      mem_addr2 <= '0;
      mem_din   <= '0;
      pipe_v    <= '0;
      pipe_oob  <= '0;
      err_oob   <= 1'b0;
    end else begin
      mem_we <= wr_acc && !wr_oob;
      if (wr_acc && !wr_oob) begin
        mem_addr1 <= wr_addr;
        mem_din   <= wr_data;
      end else if (rd_acc) begin
        // An out-of-range read still runs through the memory, parked on row 0.
        mem_addr1 <= rd_oob ? '0 : rd_addr1;
        mem_addr2 <= rd_oob ? '0 : rd_addr2;
      end
      pipe_v   <= {pipe_v[BMEM_RD_LAT-2:0], rd_acc};
      pipe_oob <= {pipe_oob[BMEM_RD_LAT-2:0], rd_acc && rd_oob};
      if ((wr_acc && wr_oob) || (rd_acc && rd_oob)) begin
        err_oob <= 1'b1;
      end
    end
  end

  assign rsp_valid = pipe_v[BMEM_RD_LAT-1];
  assign rsp_oob   = pipe_oob[BMEM_RD_LAT-1];
  assign rsp_data1 = mem_dout1;
  assign rsp_data2 = mem_dout2;

endmodule

// File: tb/tb_bmem_port_arbiter.sv
// tb/tb_bmem_port_arbiter.sv - scoreboard bench for bmem_port_arbiter with a behavioural row memory
module tb_bmem_port_arbiter;

  localparam int DEPTH = 480;
  localparam int AW    = 9;
  localparam int DW    = 5120;
  localparam int REP   = DW / 32;
  localparam logic [31:0] SALT_A = 32'hA5A5_0000;
  localparam logic [31:0] SALT_B = 32'h5A5A_1234;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data1;
  logic [DW-1:0] rsp_data2;
  logic          rsp_oob;
  logic          mem_we;
  logic [AW-1:0] mem_addr1;
  logic [AW-1:0] mem_addr2;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout1;
  logic [DW-1:0] mem_dout2;
  logic          err_oob;

  always #5 clk = ~clk;

  bmem_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rsp_valid (rsp_valid),
    .rsp_data1 (rsp_data1),
    .rsp_data2 (rsp_data2),
    .rsp_oob   (rsp_oob),
    .mem_we    (mem_we),
    .mem_addr1 (mem_addr1),
    .mem_addr2 (mem_addr2),
    .mem_din   (mem_din),
    .mem_dout1 (mem_dout1),
    .mem_dout2 (mem_dout2),
    .err_oob   (err_oob)
  );

  logic [DW-1:0] ram [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr1] <= mem_din;
    mem_dout1 <= ram[mem_addr1];
    mem_dout2 <= ram[mem_addr2];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            at;
    logic          oob;
    logic          chkd;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int r, input logic [31:0] salt);
    logic [31:0] w;
    w = (32'(r) * 32'h0100_0193) ^ salt;
    return {REP{w}};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.at));
        chk("rsp_oob", 64'(rsp_oob), 64'(e.oob));
        if (e.chkd) begin
          chk("rsp_data1_match", 64'(rsp_data1 === e.d1), 64'd1);
          chk("rsp_data2_match", 64'(rsp_data2 === e.d2), 64'd1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_valid = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    chk("wr_ready", 64'(wr_ready), 64'd1);
    chk("rd_ready_on_write", 64'(rd_ready), 64'd0);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic oob,
                         input logic chkd, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    exp_t e;
    wr_valid = 1'b0;
    rd_valid = 1'b1;
    rd_addr1 = a1;
    rd_addr2 = a2;
    e.at = cyc + 2; e.oob = oob; e.chkd = chkd; e.d1 = d1; e.d2 = d2;
    sb.push_back(e);
    #1;
    chk("rd_ready", 64'(rd_ready), 64'd1);
    step();
    rd_valid = 1'b0;
  endtask

  initial begin
    logic expw;
    logic prev_w;
    exp_t e;
    rst = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
    prev_w = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_wr_ready", 64'(wr_ready), 64'd0);
    chk("reset_rd_ready", 64'(rd_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_oob", 64'(rsp_oob), 64'd0);
    chk("reset_mem_we", 64'(mem_we), 64'd0);
    chk("reset_mem_addr1", 64'(mem_addr1), 64'd0);
    chk("reset_mem_addr2", 64'(mem_addr2), 64'd0);
    chk("reset_mem_din_zero", 64'(mem_din == '0), 64'd1);
    chk("reset_err_oob", 64'(err_oob), 64'd0);
    step();

    for (int r = 0; r < 8; r++) do_write(AW'(r), pat(r, SALT_A));
    step();

    // Four back-to-back reads; responses must land in four consecutive cycles.
    for (int i = 0; i < 4; i++)
      do_read(AW'(2*i), AW'(2*i+1), 1'b0, 1'b1, pat(2*i, SALT_A), pat(2*i+1, SALT_A));
    step(); step(); step();

    // Read-after-write on row 5.
    wr_valid = 1'b1; wr_addr = 9'd5; wr_data = pat(5, SALT_B);
    #1;
    chk("raw_wr_ready", 64'(wr_ready), 64'd1);
    step();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr1 = 9'd5; rd_addr2 = 9'd6;
    e.at = cyc + 2; e.oob = 1'b0; e.chkd = 1'b1; e.d1 = pat(5, SALT_B); e.d2 = pat(6, SALT_A);
    sb.push_back(e);
    #1;
    chk("raw_rd_ready", 64'(rd_ready), 64'd1);
    chk("raw_mem_we", 64'(mem_we), 64'd1);
    chk("raw_mem_addr1_wr", 64'(mem_addr1), 64'd5);
    chk("raw_mem_din_match", 64'(mem_din === pat(5, SALT_B)), 64'd1);
    step();
    rd_valid = 1'b0;
    #1;
    chk("raw_rd_mem_we", 64'(mem_we), 64'd0);
    chk("raw_rd_mem_addr1", 64'(mem_addr1), 64'd5);
    chk("raw_rd_mem_addr2", 64'(mem_addr2), 64'd6);
    step(); step();

    // Reset lands while a read is in flight; its response must vanish.
    rd_valid = 1'b1; rd_addr1 = 9'd2; rd_addr2 = 9'd3;
    #1;
    chk("inflight_rd_ready", 64'(rd_ready), 64'd1);
    step();
    rd_valid = 1'b0; rst = 1'b1;
    #1;
    chk("inflight_cmd_addr1", 64'(mem_addr1), 64'd2);
    step();
    rst = 1'b0;
    #1;
    chk("inflight_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("inflight_mem_we", 64'(mem_we), 64'd0);
    chk("inflight_mem_addr1", 64'(mem_addr1), 64'd0);
    chk("inflight_mem_addr2", 64'(mem_addr2), 64'd0);
    chk("inflight_mem_din_zero", 64'(mem_din == '0), 64'd1);
    chk("inflight_err_oob", 64'(err_oob), 64'd0);
    chk("inflight_rsp_oob", 64'(rsp_oob), 64'd0);
    step(); step();

    // Both requesters held valid straight after reset.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 9'd10; wr_data = pat(10, SALT_A);
      rd_valid = 1'b1; rd_addr1 = 9'd0; rd_addr2 = 9'd1;
`ifdef BMEM_ARB_WR_PRIO_EN
      expw = 1'b1;
`else
      expw = (i % 2 == 0);
`endif
      if (!expw) begin
        e.at = cyc + 2; e.oob = 1'b0; e.chkd = 1'b1; e.d1 = pat(0, SALT_A); e.d2 = pat(1, SALT_A);
        sb.push_back(e);
      end
      #1;
      chk("fair_wr_ready", 64'(wr_ready), 64'(expw));
      chk("fair_rd_ready", 64'(rd_ready), 64'(!expw));
      if (i > 0) chk("fair_mem_we", 64'(mem_we), 64'(prev_w));
      prev_w = expw;
      step();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    #1;
    chk("fair_mem_we_last", 64'(mem_we), 64'(prev_w));
    step(); step(); step();

    // Out-of-range write, then the last valid row.
    chk("pre_oob_err", 64'(err_oob), 64'd0);
    do_write(9'd480, pat(480, SALT_A));
    #1;
    chk("oob_wr_mem_we", 64'(mem_we), 64'd0);
    chk("oob_wr_err", 64'(err_oob), 64'd1);
    step();
    do_write(9'd479, pat(479, SALT_A));
    #1;
    chk("wr479_mem_we", 64'(mem_we), 64'd1);
    chk("wr479_mem_addr1", 64'(mem_addr1), 64'd479);
    chk("wr479_err_sticky", 64'(err_oob), 64'd1);
    step();

    do_read(9'd479, 9'd500, 1'b1, 1'b0, '0, '0);
    #1;
    chk("oob_rd_mem_addr1", 64'(mem_addr1), 64'd0);
    chk("oob_rd_mem_addr2", 64'(mem_addr2), 64'd0);
    chk("oob_rd_mem_we", 64'(mem_we), 64'd0);
    chk("oob_rd_err", 64'(err_oob), 64'd1);
    step(); step();

    do_read(9'd479, 9'd0, 1'b0, 1'b1, pat(479, SALT_A), pat(0, SALT_A));
    step(); step(); step();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
